// File: rtl/kw_ram_pkg.sv
// Shared types and parameter limits for the kw_ram flip-flop RAM family.
package kw_ram_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_DEPTH      = 256;
    localparam int MAX_NUM_RD     = 4;

endpackage

// File: rtl/kw_ram_init_seq.sv
// Post-reset array clear sequencer: walks word 0..DEPTH-1 writing zero, then idles in READY.
module kw_ram_init_seq
    import kw_ram_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_init_busy,
    output logic                  o_init_we,
    output logic [ADDR_WIDTH-1:0] o_init_addr,
    output init_state_e           o_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    init_state_e           r_state;
    init_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            INIT: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = READY;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = INIT;
        endcase
    end

    assign o_init_busy = (r_state == INIT);
    assign o_init_we   = (r_state == INIT);
    assign o_init_addr = r_cnt;
    assign o_state     = r_state;

endmodule

// File: rtl/kw_ram_nr1w_dff.sv
// Flip-flop RAM, one byte-masked write port, NUM_RD read ports (async or registered).
// Optional per-byte even parity with rd_perr output when KW_RAM_PARITY_EN is defined.
module kw_ram_nr1w_dff
    import kw_ram_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  BYTE_WIDTH = 8,
    parameter int  DEPTH      = 64,
    parameter int  NUM_RD     = 2,
    parameter int  RD_LATENCY = 0,
    parameter int  ADDR_WIDTH = $clog2(DEPTH),
    localparam int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                                 clock,
    input  logic                                 reset,
    output logic                                 init_busy,
    input  logic                                 wr_en,
    input  logic [ADDR_WIDTH-1:0]                wr_addr,
    input  logic [NUM_BYTES-1:0]                 wr_mask,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic [NUM_RD-1:0]                    rd_en,
    input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_RD-1:0]                    rd_valid
`ifdef KW_RAM_PARITY_EN
    ,
    output logic [NUM_RD-1:0][NUM_BYTES-1:0]     rd_perr
`endif
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_dw
        $fatal(1, "kw_ram_nr1w_dff: DATA_WIDTH out of range or not a multiple of BYTE_WIDTH");
    end
    if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $fatal(1, "kw_ram_nr1w_dff: DEPTH out of range");
    end
    if (NUM_RD < 1 || NUM_RD > MAX_NUM_RD) begin : g_bad_nrd
        $fatal(1, "kw_ram_nr1w_dff: NUM_RD out of range");
    end
    if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_lat
        $fatal(1, "kw_ram_nr1w_dff: RD_LATENCY must be 0 or 1");
    end

    typedef logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] word_t;

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    word_t                 r_mem [DEPTH];
`ifdef KW_RAM_PARITY_EN
    logic [NUM_BYTES-1:0]  r_par [DEPTH];
`endif

    logic                  w_init_busy;
    logic                  w_init_we;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    init_state_e           w_init_state;
    logic                  w_usr_we;
    word_t                 w_wr_word;

    kw_ram_init_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_init_seq (
        .i_clk       (clock),
        .i_rst       (reset),
        .o_init_busy (w_init_busy),
        .o_init_we   (w_init_we),
        .o_init_addr (w_init_addr),
        .o_state     (w_init_state)
    );

    assign init_busy = w_init_busy;
    assign w_wr_word = wr_data;
    // The user port owns the array only once the clear sequence has finished.
    assign w_usr_we  = wr_en & (w_init_state == READY) & ({1'b0, wr_addr} < DEPTH_L);

    always_ff @(posedge clock) begin
        if (w_init_we) begin
            r_mem[w_init_addr] <= '0;
`ifdef KW_RAM_PARITY_EN
            r_par[w_init_addr] <= '0;
`endif
        end else if (w_usr_we) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (wr_mask[b]) begin
                    r_mem[wr_addr][b] <= w_wr_word[b];
`ifdef KW_RAM_PARITY_EN
                    r_par[wr_addr][b] <= ^w_wr_word[b];
`endif
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic  w_hit;
        logic  w_valid;
        word_t w_word;

        assign w_hit   = ({1'b0, rd_addr[p]} < DEPTH_L);
        assign w_word  = w_hit ? r_mem[rd_addr[p]] : '0;
        assign w_valid = rd_en[p] & ~w_init_busy;

`ifdef KW_RAM_PARITY_EN
        logic [NUM_BYTES-1:0] w_perr;
        always_comb begin
            w_perr = '0;
            if (w_hit) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    w_perr[b] = r_par[rd_addr[p]][b] ^ (^r_mem[rd_addr[p]][b]);
                end
            end
        end
`endif

        if (RD_LATENCY == 0) begin : g_async
            assign rd_data[p]  = w_word;
            assign rd_valid[p] = w_valid;
`ifdef KW_RAM_PARITY_EN
            assign rd_perr[p]  = w_perr;
`endif
        end else begin : g_reg
            word_t r_data;
            logic  r_valid;
`ifdef KW_RAM_PARITY_EN
            logic [NUM_BYTES-1:0] r_perr;
`endif
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
`ifdef KW_RAM_PARITY_EN
                    r_perr  <= '0;
`endif
                end else begin
                    r_valid <= w_valid;
                    if (rd_en[p]) begin
                        r_data <= w_word;
`ifdef KW_RAM_PARITY_EN
                        r_perr <= w_perr;
`endif
                    end
                end
            end
            assign rd_data[p]  = r_data;
            assign rd_valid[p] = r_valid;
`ifdef KW_RAM_PARITY_EN
            assign rd_perr[p]  = r_perr;
`endif
        end
    end

endmodule

// File: tb/tb_kw_ram_nr1w_dff.sv
// Directed bench: an async-read DEPTH=64 instance and a registered-read DEPTH=48 instance share stimulus.
module tb_kw_ram_nr1w_dff;

    logic             clock;
    logic             reset;
    logic             wr_en;
    logic [5:0]       wr_addr;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;
    logic [1:0]       rd_en;
    logic [1:0][5:0]  rd_addr;

    logic             busy0, busy1;
    logic [1:0][31:0] rd_data0, rd_data1;
    logic [1:0]       rd_valid0, rd_valid1;
`ifdef KW_RAM_PARITY_EN
    logic [1:0][3:0]  rd_perr0, rd_perr1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    kw_ram_nr1w_dff #(
        .DATA_WIDTH (32), .BYTE_WIDTH (8), .DEPTH (64), .NUM_RD (2), .RD_LATENCY (0)
    ) u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .init_busy (busy0),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data0),
        .rd_valid  (rd_valid0)
`ifdef KW_RAM_PARITY_EN
        ,
        .rd_perr   (rd_perr0)
`endif
    );

    kw_ram_nr1w_dff #(
        .DATA_WIDTH (32), .BYTE_WIDTH (8), .DEPTH (48), .NUM_RD (2), .RD_LATENCY (1)
    ) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .init_busy (busy1),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data1),
        .rd_valid  (rd_valid1)
`ifdef KW_RAM_PARITY_EN
        ,
        .rd_perr   (rd_perr1)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] m, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_mask = m;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Count edges until each instance leaves init; user writes stay requested for wr_cycles edges.
    task automatic run_init(input int wr_cycles);
        int n, d0, d1;
        n  = 0;
        d0 = -1;
        d1 = -1;
        while ((busy0 || busy1) && n < 300) begin
            tick();
            n++;
            if (n == wr_cycles) wr_en = 1'b0;
            if (!busy0 && d0 < 0) d0 = n;
            if (!busy1 && d1 < 0) d1 = n;
        end
        wr_en = 1'b0;
        chk("busy_len0", 64'(d0), 64'd64);
        chk("busy_len1", 64'(d1), 64'd48);
    endtask

    initial begin
        logic [31:0] or0, or1;
        logic [1:0]  and0, and1;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_mask = '0;
        wr_data = '0;
        rd_en   = 2'b11;
        rd_addr = '0;
        repeat (3) tick();
        chk("rst_busy0",  64'(busy0), 64'd1);
        chk("rst_busy1",  64'(busy1), 64'd1);
        chk("rst_valid0", 64'(rd_valid0), 64'd0);
        chk("rst_valid1", 64'(rd_valid1), 64'd0);
        chk("rst_data1",  64'(rd_data1), 64'd0);

        reset = 1'b0;
        run_init(0);

        or0  = '0;
        or1  = '0;
        and0 = 2'b11;
        and1 = 2'b11;
        for (int a = 0; a < 64; a++) begin
            rd_addr[0] = 6'(a);
            rd_addr[1] = 6'(63 - a);
            tick();
            or0  = or0 | rd_data0[0] | rd_data0[1];
            or1  = or1 | rd_data1[0] | rd_data1[1];
            and0 = and0 & rd_valid0;
            and1 = and1 & rd_valid1;
        end
        chk("init_zero0",  64'(or0), 64'd0);
        chk("init_zero1",  64'(or1), 64'd0);
        chk("init_valid0", 64'(and0), 64'd3);
        chk("init_valid1", 64'(and1), 64'd3);

        // Byte-masked writes: byte 1 replaced, mask 0 is a no-op.
        wr(6'd5, 4'hF, 32'hDEADBEEF);
        wr(6'd5, 4'b0010, 32'h0000AA00);
        wr(6'd5, 4'h0, 32'hFFFFFFFF);
        rd_en      = 2'b01;
        rd_addr[0] = 6'd5;
        rd_addr[1] = 6'd0;
        #1;
        chk("mask_rd0", 64'(rd_data0[0]), 64'hDEADAAEF);
        tick();
        chk("mask_rd1",   64'(rd_data1[0]), 64'hDEADAAEF);
        chk("mask_vld1",  64'(rd_valid1), 64'd1);

        // Read-during-write returns the old word on both ports.
        rd_en      = 2'b11;
        rd_addr[0] = 6'd5;
        rd_addr[1] = 6'd5;
        wr_en      = 1'b1;
        wr_addr    = 6'd5;
        wr_mask    = 4'hF;
        wr_data    = 32'h12345678;
        #1;
        chk("rdw_old0",  64'(rd_data0[1]), 64'hDEADAAEF);
        chk("rdw_vld0",  64'(rd_valid0), 64'd3);
        tick();
        wr_en = 1'b0;
        chk("rdw_old1p0", 64'(rd_data1[0]), 64'hDEADAAEF);
        chk("rdw_old1p1", 64'(rd_data1[1]), 64'hDEADAAEF);
        chk("rdw_vld1",   64'(rd_valid1), 64'd3);
        chk("rdw_new0",   64'(rd_data0[0]), 64'h12345678);
        tick();
        chk("rdw_new1",   64'(rd_data1[1]), 64'h12345678);

        // Registered port holds data when not enabled.
        rd_en      = 2'b10;
        rd_addr[0] = 6'd0;
        tick();
        chk("hold_data1", 64'(rd_data1[0]), 64'h12345678);
        chk("hold_vld1",  64'(rd_valid1), 64'd2);
        chk("hold_data0", 64'(rd_data0[0]), 64'd0);
        chk("hold_vld0",  64'(rd_valid0), 64'd2);

        // Address 50 is in range for DEPTH=64 but not for DEPTH=48.
        wr(6'd47, 4'hF, 32'h47474747);
        wr(6'd50, 4'hF, 32'hCAFEF00D);
        rd_en      = 2'b11;
        rd_addr[0] = 6'd50;
        rd_addr[1] = 6'd47;
        tick();
        chk("oor_rd1",  64'(rd_data1[0]), 64'd0);
        chk("d47_rd1",  64'(rd_data1[1]), 64'h47474747);
        chk("d50_rd0",  64'(rd_data0[0]), 64'hCAFEF00D);
        chk("d47_rd0",  64'(rd_data0[1]), 64'h47474747);

        // Reset during init at counter 20 restarts the full sweep.
        reset = 1'b1;
        tick();
        chk("rst2_data1",  64'(rd_data1), 64'd0);
        chk("rst2_valid1", 64'(rd_valid1), 64'd0);
        reset = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        tick();
        chk("rst3_busy0", 64'(busy0), 64'd1);
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 6'd3;
        wr_mask = 4'hF;
        wr_data = 32'h33333333;
        run_init(5);
        rd_addr[0] = 6'd3;
        rd_addr[1] = 6'd5;
        tick();
        chk("busywr_rd0", 64'(rd_data0[0]), 64'd0);
        chk("busywr_rd1", 64'(rd_data1[0]), 64'd0);
        chk("reinit_rd0", 64'(rd_data0[1]), 64'd0);
        rd_addr[0] = 6'd50;
        rd_addr[1] = 6'd47;
        tick();
        chk("reinit50_rd0", 64'(rd_data0[0]), 64'd0);
        chk("reinit47_rd1", 64'(rd_data1[1]), 64'd0);

`ifdef KW_RAM_PARITY_EN
        wr(6'd7, 4'hF, 32'h00001100);
        rd_addr[0] = 6'd7;
        rd_addr[1] = 6'd6;
        tick();
        chk("perr_clean", 64'(rd_perr0), 64'd0);
        u_dut0.r_mem[7][1][0] = ~u_dut0.r_mem[7][1][0];
        #1;
        chk("perr_p0", 64'(rd_perr0[0]), 64'h2);
        chk("perr_p1", 64'(rd_perr0[1]), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
